fetch_request_unit: RTL
=======================

// Module: fetch_request_unit
// PURPOSE
//  Datapath-side consumer of control_unit_if outputs. Sequences fetch and data-memory
//  requests: holds the PC, gates imemREN, and holds dmemREN/dmemWEN until hit.
//  Updates PC from PCSrc once an instruction retires, and latches halt.
//  Sits between the control unit, the register file/ALU and the memory arbiter.
// PARAMETERS
//  PC_RESET        32'h0000_0000  PC value loaded on reset
//  TIMEOUT_CYCLES  255            wait-for-hit limit (used only with FRU_TIMEOUT_EN)
// PORTS
//  CLK            in   1   system clock, rising edge
//  nRST           in   1   asynchronous active-low reset
//  cu_imemREN     in   1   control unit fetch enable
//  cu_dmemreq     in   1   decoded instruction is a load
//  cu_dmemwreq    in   1   decoded instruction is a store
//  cu_halt        in   1   decoded instruction is HALT
//  cu_PCSrc       in   2   0 PC+4, 1 branch taken, 2 J/JAL, 3 JR
//  br_imm         in   16  branch immediate (instr[15:0])
//  j_addr         in   26  jump address field (instr[25:0])
//  jr_target      in   32  rs register value for JR
//  ihit           in   1   instruction memory hit
//  dhit           in   1   data memory hit
//  imemREN        out  1   instruction read request
//  imemaddr       out  32  equals pc
//  dmemREN        out  1   data read request
//  dmemWEN        out  1   data write request
//  pc             out  32  current PC
//  pc_plus4       out  32  pc + 4 (for JAL link)
//  halt           out  1   sticky halt flag
//  req_timeout    out  1   sticky hit-timeout flag
// BEHAVIOUR
//  - Reset values: pc=PC_RESET, state FETCH, halt=0, dmemREN=dmemWEN=0, req_timeout=0.
//  - FETCH: imemREN=cu_imemREN. On ihit:
//    - cu_halt=1 -> HALTED. PC is not updated. halt wins over any mem request.
//    - else if cu_dmemreq|cu_dmemwreq -> DATA. Register dmemREN=cu_dmemreq and
//      dmemWEN=cu_dmemwreq from the next cycle. PC is held.
//    - else -> PC<=next_pc; stay in FETCH.
//  - DATA: imemREN=0; dmemREN/dmemWEN stay stable until dhit.
//    On dhit, both are cleared, PC<=next_pc, and the state returns to FETCH.
//    Both cleared in the same edge; next fetch starts the following cycle.
//  - HALTED: all requests 0, halt=1. Sticky; only nRST exits.
//  - ihit is ignored outside FETCH. dhit is ignored outside DATA.
//    ihit&dhit together: only the hit for the current state acts.
//  - next_pc (32-bit, wraps mod 2^32, no overflow flag):
//    - PCSrc 0: pc+4.
//    - PCSrc 1: pc+4 + (sext(br_imm)<<2).
//    - PCSrc 2: {pc_plus4[31:28], j_addr, 2'b00}.
//    - PCSrc 3: jr_target.
//  - cu_* and target inputs are sampled only on the retiring edge.
//    They must be stable while the same instruction is held.
//  - Reset mid-DATA drops dmemREN/dmemWEN immediately (async) and restarts fetch at PC_RESET.
// CONFIGURATION
//  FRU_TIMEOUT_EN defined: counter clears on state entry and increments each FETCH/DATA cycle without hit.
//    At TIMEOUT_CYCLES it sets req_timeout (sticky); the request stays asserted.
//  FRU_TIMEOUT_EN undefined: no counter; req_timeout tied 0.
// STRUCTURE
//  cpu_types_pkg gains: pcsrc_t enum {PC_NEXT,PC_BRANCH,PC_JUMP,PC_JR}
//    and fru_state_t enum {FRU_FETCH,FRU_DATA,FRU_HALTED}.
//  Sub-module next_pc_sel: combinational PCSrc mux/adders producing next_pc.
//  State register, PC register and request flops stay in fetch_request_unit.
// TESTING
//  1 Reset then ihit with PCSrc=0, no req -> pc 0x0 then 0x4; imemREN=1 throughout.
//  2 pc=0x100, load decoded, ihit -> dmemREN=1 next cycle, pc holds 0x100.
//    Then 3 cycles later dhit -> dmemREN=0, pc=0x104.
//  3 pc=0x200, PCSrc=1, br_imm=16'hFFFE, ihit -> pc=0x1FC.
//    PCSrc=2, j_addr=26'h10 -> pc={4'h0,26'h10,2'b00}=0x40.
//    PCSrc=3, jr_target=0x8000_0000 -> pc=0x8000_0000.
//  4 pc=0xFFFF_FFFC, PCSrc=0, ihit -> pc wraps to 0x0.
//    Halt with cu_dmemwreq=1, ihit -> halt=1, dmemWEN stays 0, later ihits ignored.
//  5 nRST low during DATA with dmemWEN=1 -> dmemWEN=0 asynchronously; after release pc=PC_RESET.
//  6 FRU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no dhit for 4 cycles -> req_timeout=1, dmemREN still 1.
//    Without the macro -> req_timeout=0.

Source files
------------

// File: rtl/fetch_request_unit_pkg.sv
// Shared CPU types: PC source select and fetch/request sequencer states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_JR     = 2'd3
    } pcsrc_t;

    typedef enum logic [1:0] {
        FRU_FETCH  = 2'd0,
        FRU_DATA   = 2'd1,
        FRU_HALTED = 2'd2
    } fru_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_request_unit_if.sv
// Memory-arbiter handshake between the fetch/request unit (master) and the arbiter (slave).
interface fetch_request_unit_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic        dmemREN;
    logic        dmemWEN;
    logic        dhit;

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN,
        input  ihit, dhit
    );

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN,
        output ihit, dhit
    );

endinterface

// File: rtl/fetch_request_unit_next_pc_sel.sv
// Combinational next-PC selection: sequential, branch, jump and register-jump targets.
module next_pc_sel
    import cpu_types_pkg::*;
(
    input  logic [31:0] pc,
    input  pcsrc_t      pcsrc,
    input  logic [15:0] br_imm,
    input  logic [25:0] j_addr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] br_off;

    assign pc_plus4 = pc + PC_STEP;
    assign br_off   = {{14{br_imm[15]}}, br_imm, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        case (pcsrc)
            PC_NEXT:   next_pc = pc_plus4;
            PC_BRANCH: next_pc = pc_plus4 + br_off;
            PC_JUMP:   next_pc = {pc_plus4[31:28], j_addr, 2'b00};
            PC_JR:     next_pc = jr_target;
            default:   next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_request_unit.sv
// Fetch/data request sequencer: holds PC, gates fetch, holds data requests until hit.
// Optional wait-for-hit timeout flag enabled by defining FRU_TIMEOUT_EN.
module fetch_request_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] PC_RESET       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        CLK,
    input  logic                        nRST,
    input  logic                        cu_imemREN,
    input  logic                        cu_dmemreq,
    input  logic                        cu_dmemwreq,
    input  logic                        cu_halt,
    input  logic [1:0]                  cu_PCSrc,
    input  logic [15:0]                 br_imm,
    input  logic [25:0]                 j_addr,
    input  logic [31:0]                 jr_target,
    fetch_request_unit_if.master        mem,
    output logic [31:0]                 pc,
    output logic [31:0]                 pc_plus4,
    output logic                        halt,
    output logic                        req_timeout
);

    fru_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        dmem_ren_q, dmem_ren_d;
    logic        dmem_wen_q, dmem_wen_d;
    logic        halt_q, halt_d;
    logic        imem_ren;
    logic [31:0] next_pc;

    next_pc_sel u_next_pc_sel (
        .pc        (pc_q),
        .pcsrc     (pcsrc_t'(cu_PCSrc)),
        .br_imm    (br_imm),
        .j_addr    (j_addr),
        .jr_target (jr_target),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        dmem_ren_d = dmem_ren_q;
        dmem_wen_d = dmem_wen_q;
        halt_d     = halt_q;
        imem_ren   = 1'b0;
        case (state_q)
            FRU_FETCH: begin
                imem_ren = cu_imemREN;
                if (mem.ihit) begin
                    // halt takes priority over any memory request of the same instruction
                    if (cu_halt) begin
                        state_d = FRU_HALTED;
                        halt_d  = 1'b1;
                    end else if (cu_dmemreq || cu_dmemwreq) begin
                        state_d    = FRU_DATA;
                        dmem_ren_d = cu_dmemreq;
                        dmem_wen_d = cu_dmemwreq;
                    end else begin
                        pc_d = next_pc;
                    end
                end
            end
            FRU_DATA: begin
                if (mem.dhit) begin
                    state_d    = FRU_FETCH;
                    dmem_ren_d = 1'b0;
                    dmem_wen_d = 1'b0;
                    pc_d       = next_pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= FRU_FETCH;
            pc_q       <= PC_RESET;
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            dmem_ren_q <= dmem_ren_d;
            dmem_wen_q <= dmem_wen_d;
            halt_q     <= halt_d;
        end
    end

`ifdef FRU_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        req_timeout_q, req_timeout_d;
    logic        waiting;

    // A hit or state change restarts the count; it saturates once the flag is set.
    always_comb begin
        waiting       = ((state_q == FRU_FETCH) && !mem.ihit) ||
                        ((state_q == FRU_DATA)  && !mem.dhit);
        tmo_cnt_d     = '0;
        req_timeout_d = req_timeout_q;
        if (waiting) begin
            tmo_cnt_d = (tmo_cnt_q < TIMEOUT_CYCLES) ? tmo_cnt_q + 32'd1 : tmo_cnt_q;
            if (tmo_cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
                req_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            tmo_cnt_q     <= '0;
            req_timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            req_timeout_q <= req_timeout_d;
        end
    end

    assign req_timeout = req_timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign req_timeout        = 1'b0;
`endif

    assign mem.imemREN  = imem_ren;
    assign mem.imemaddr = pc_q;
    assign mem.dmemREN  = dmem_ren_q;
    assign mem.dmemWEN  = dmem_wen_q;
    assign pc           = pc_q;
    assign halt         = halt_q;

endmodule
